// File: rtl/tlul_scratch_mem.sv
// rtl/tlul_scratch_mem.sv - TL-UL device scratch memory with configurable response latency; optional macro TLUL_SCRATCH_TXN_CNT_EN
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [7:0]  d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_scratch_mem
    import tlul_pkg::*;
#(
    parameter int unsigned Depth    = 64,
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned Latency  = 0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o
);

    localparam int          IW   = $clog2(Depth);
    localparam logic [31:0] SPAN = 32'(4 * Depth);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state;
    logic [3:0]  wait_cnt;
    logic [2:0]  req_opcode;
    logic [31:0] req_address;
    logic [1:0]  req_size;
    logic [7:0]  req_source;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic [31:0] d_data_q;
    logic        d_error_q;
    logic [31:0] mem [Depth];

    logic          a_ready;
    logic          accept;
    logic          is_get;
    logic          is_write;
    logic          opcode_ok;
    logic          above_base;
    logic          mem_hit;
    logic          cnt_hit;
    logic          req_err;
    logic [31:0]   offset;
    logic [IW-1:0] word_idx;
    logic [31:0]   cnt_rd;
    logic [3:0]    byte_en;
    logic          unused_req;

    // Captured address/data/mask are kept for observability only.
    assign unused_req = ^{req_address, req_data, req_mask};

    assign a_ready    = (state == IDLE) && !rst_i;
    assign accept     = tl_i.a_valid && a_ready;
    assign is_get     = tl_i.a_opcode == Get;
    assign is_write   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign opcode_ok  = is_get || is_write;
    assign above_base = tl_i.a_address >= BaseAddr;
    assign offset     = tl_i.a_address - BaseAddr;
    assign mem_hit    = above_base && (offset < SPAN);
    assign word_idx   = offset[IW+1:2];
    assign byte_en    = (tl_i.a_opcode == PutFullData) ? 4'hf : tl_i.a_mask;
    assign req_err    = !(mem_hit || cnt_hit)
                      || (tl_i.a_address[1:0] != 2'b00)
                      || (tl_i.a_size > 2'd2)
                      || !opcode_ok
                      || ((tl_i.a_opcode == PutFullData) && (tl_i.a_size == 2'd2)
                          && (tl_i.a_mask != 4'hf));

`ifdef TLUL_SCRATCH_TXN_CNT_EN
    logic [31:0] txn_cnt;

    assign cnt_hit = above_base && (offset == SPAN);
    assign cnt_rd  = txn_cnt;

    // Count completed D handshakes; an error-free write to the counter word clears it at acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txn_cnt <= 32'd0;
        end else if (accept && is_write && cnt_hit && !req_err) begin
            txn_cnt <= 32'd0;
        end else if ((state == RESP) && tl_i.d_ready) begin
            txn_cnt <= txn_cnt + 32'd1;
        end
    end
`else
    assign cnt_hit = 1'b0;
    assign cnt_rd  = 32'd0;
`endif

    // Byte-masked memory write at the acceptance edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && is_write && mem_hit && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM: accept in IDLE, optional wait, hold response until d_ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            req_opcode  <= 3'd0;
            req_address <= 32'd0;
            req_size    <= 2'd0;
            req_source  <= 8'd0;
            req_data    <= 32'd0;
            req_mask    <= 4'd0;
            d_data_q    <= 32'd0;
            d_error_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_opcode  <= tl_i.a_opcode;
                        req_address <= tl_i.a_address;
                        req_size    <= tl_i.a_size;
                        req_source  <= tl_i.a_source;
                        req_data    <= tl_i.a_data;
                        req_mask    <= tl_i.a_mask;
                        d_error_q   <= req_err;
                        d_data_q    <= (req_err || !is_get) ? 32'd0
                                     : (cnt_hit ? cnt_rd : mem[word_idx]);
                        wait_cnt    <= (Latency > 0) ? 4'(Latency - 1) : 4'd0;
                        state       <= (Latency > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (tl_i.d_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Drive the D channel straight from the captured request and response registers.
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = state == RESP;
        tl_o.d_opcode = (req_opcode == Get) ? AccessAckData : AccessAck;
        tl_o.d_param  = 3'd0;
        tl_o.d_size   = req_size;
        tl_o.d_source = req_source;
        tl_o.d_sink   = req_source;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
    end

endmodule
